iterative_square: RTL and testbench
===================================

# iterative_square

Iterative unsigned squarer with elastic valid/ready handshakes. It is the inverse companion of the iterative square-root kernel: it takes a root value plus a start control token, computes root² by shift-add over WIDTH cycles, and returns the result plus an end token. It sits in the same dataflow kernel fabric and is used to re-square sqrt results for round-trip checking and in kernels that need x² without a DSP multiplier.

## Interface
- WIDTH, 8, operand width in bits; result width is 2*WIDTH
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous reset, active-low (asserted when 0)
- r  in  WIDTH  unsigned operand
- r_valid  in  1  operand valid
- r_ready  out  1  operand accepted
- start_valid  in  1  start control token valid
- start_ready  out  1  start token accepted
- out0  out  2*WIDTH  unsigned result r*r
- out0_valid  out  1  result valid
- out0_ready  in  1  result consumer ready
- end_valid  out  1  end control token valid
- end_ready  in  1  end token consumer ready

## Operation
- FSM states: IDLE, COMPUTE, DONE.
- IDLE: join of r and start. r_ready = start_ready = r_valid & start_valid (combinational). Both handshakes occur in the same cycle; never consume one without the other. On the handshake: latch mcand = r, mplier = r, acc = 0, cnt = 0, go to COMPUTE.
- COMPUTE: each cycle, if mplier[0], acc += mcand; mcand <<= 1 (2*WIDTH-bit register); mplier >>= 1; cnt++. After WIDTH iterations (cnt == WIDTH-1 on the last), go to DONE. r_ready/start_ready = 0.
- DONE: out0 = acc, out0_valid and end_valid are asserted independently. Per-output sent flags: out0_sent set on out0_valid & out0_ready, end_sent on end_valid & end_ready. Once a flag is set, the corresponding valid deasserts. When both flags are set (including both firing in the same cycle, or the second one firing), clear the flags and go to IDLE.
- Arithmetic: unsigned, no overflow possible ((2^WIDTH−1)² < 2^(2*WIDTH)); acc has no carry-out.
- Valids never depend combinationally on readys; out0 is held stable while out0_valid = 1.

## Timing
- Reset (rst = 0, async): state IDLE, acc/mcand/mplier/cnt/flags = 0. Outputs: out0 = 0, out0_valid = 0, end_valid = 0; r_ready/start_ready follow inputs but are gated low while rst = 0.
- Reset mid-COMPUTE or mid-DONE: partial result discarded, no output is emitted; the next handshake after deassertion starts fresh.
- Latency: input handshake in cycle T → COMPUTE in T+1..T+WIDTH → out0_valid/end_valid high from T+WIDTH+1.
- Both outputs taken in cycle X → IDLE at X+1; earliest next input handshake is X+1. Throughput with no backpressure: one result per WIDTH+2 cycles.
- Inputs valid in COMPUTE/DONE are held off (ready = 0) and are not lost.

## Structure
- Shared package/header: state encoding localparams (IDLE/COMPUTE/DONE), default WIDTH, counter width = clog2(WIDTH).
- One natural sub-module: iterative_square_dp (mcand/mplier/acc/cnt registers with load and step controls); FSM and handshake join/fork logic stay in the top-level.

## Test plan
- r=13 with start, readys high → out0=169 with out0_valid and end_valid asserted exactly 9 cycles after the handshake, both drop the following cycle.
- r=0 → out0=0; r=255 → out0=65025 (0xFE01), same latency.
- r_valid=1, start_valid=0 for 5 cycles → r_ready=0 throughout; raise start_valid → both readys pulse together in one cycle.
- r=200, out0_ready=0 and end_ready=1 → end token taken immediately, end_valid drops; out0=40000 held stable until out0_ready raised 4 cycles later; IDLE the next cycle.
- Back-to-back operands 3,4,5 with continuous valids → results 9,16,25 spaced 10 cycles apart, no drops or duplicates.
- rst pulled low 3 cycles into COMPUTE for r=100 → outputs 0 immediately, no result emitted; after release r=7 → 49.

Source files
------------

// File: rtl/iterative_square_pkg.sv
// Shared types and constants for the iterative shift-add squarer.
package iterative_square_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    // Iteration counter width; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/iterative_square_dp.sv
// Shift-add datapath: one multiplier bit is consumed per step, accumulating r*r.
module iterative_square_dp
    import iterative_square_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CW = cnt_width(WIDTH)
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_load,
    input  logic               i_step,
    input  logic [WIDTH-1:0]   i_operand,
    output logic [2*WIDTH-1:0] o_acc,
    output logic               o_last
);

    logic [2*WIDTH-1:0] r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mplier;
    logic [CW-1:0]      r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mcand  <= '0;
            r_acc    <= '0;
            r_mplier <= '0;
            r_cnt    <= '0;
        end else if (i_load) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_operand};
            r_acc    <= '0;
            r_mplier <= i_operand;
            r_cnt    <= '0;
        end else if (i_step) begin
            // (2^W-1)^2 fits in 2W bits, so the accumulator never carries out.
            if (r_mplier[0]) begin
                r_acc <= r_acc + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CW'(1);
        end
    end

    assign o_acc  = r_acc;
    assign o_last = (r_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/iterative_square.sv
// Iterative squarer: joins operand and start token, squares over WIDTH cycles,
// then forks the result and end token as independent valid/ready outputs.
module iterative_square
    import iterative_square_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   r,
    input  logic               r_valid,
    output logic               r_ready,
    input  logic               start_valid,
    output logic               start_ready,
    output logic [2*WIDTH-1:0] out0,
    output logic               out0_valid,
    input  logic               out0_ready,
    output logic               end_valid,
    input  logic               end_ready,
    output state_t             o_dbg_state
);

    // Handshake rule: a transfer happens on a rising edge where valid & ready;
    // valids never look at readys, and a raised valid holds its data until taken.
    state_t r_state, w_next_state;
    logic   r_out0_sent, r_end_sent;
    logic   w_out0_sent_nx, w_end_sent_nx;
    logic   w_join, w_load, w_step, w_last;
    logic   w_out0_fire, w_end_fire, w_out0_done, w_end_done;

    iterative_square_dp #(.WIDTH(WIDTH)) u_dp (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_load    (w_load),
        .i_step    (w_step),
        .i_operand (r),
        .o_acc     (out0),
        .o_last    (w_last)
    );

    // Operand and start are consumed together or not at all.
    assign w_join      = rst & (r_state == S_IDLE) & r_valid & start_valid;
    assign r_ready     = w_join;
    assign start_ready = w_join;

    assign out0_valid  = (r_state == S_DONE) & ~r_out0_sent;
    assign end_valid   = (r_state == S_DONE) & ~r_end_sent;
    assign w_out0_fire = out0_valid & out0_ready;
    assign w_end_fire  = end_valid & end_ready;
    assign w_out0_done = r_out0_sent | w_out0_fire;
    assign w_end_done  = r_end_sent | w_end_fire;
    assign o_dbg_state = r_state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_out0_sent <= 1'b0;
            r_end_sent  <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_out0_sent <= w_out0_sent_nx;
            r_end_sent  <= w_end_sent_nx;
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_out0_sent_nx = r_out0_sent;
        w_end_sent_nx  = r_end_sent;
        w_load         = 1'b0;
        w_step         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_join) begin
                    w_load       = 1'b1;
                    w_next_state = S_COMPUTE;
                end
            end
            S_COMPUTE: begin
                w_step = 1'b1;
                if (w_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (w_out0_done && w_end_done) begin
                    w_out0_sent_nx = 1'b0;
                    w_end_sent_nx  = 1'b0;
                    w_next_state   = S_IDLE;
                end else begin
                    w_out0_sent_nx = w_out0_done;
                    w_end_sent_nx  = w_end_done;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_iterative_square.sv
// Directed bench for iterative_square: vector table plus handshake/reset sequences.
module tb_iterative_square;
    import iterative_square_pkg::*;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [W-1:0]   r = '0;
    logic           r_valid = 1'b0;
    logic           r_ready;
    logic           start_valid = 1'b0;
    logic           start_ready;
    logic [2*W-1:0] out0;
    logic           out0_valid;
    logic           out0_ready = 1'b0;
    logic           end_valid;
    logic           end_ready = 1'b0;
    state_t         dbg_state;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_end = 0;
    int n_pushed = 0;
    logic [2*W-1:0] exp_q[$];
    int fire_cyc[$];

    typedef struct {
        logic [W-1:0]   r;
        logic [2*W-1:0] exp;
    } vec_t;
    vec_t vecs[6];
    logic [W-1:0] ops[3];

    iterative_square #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .r           (r),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .out0        (out0),
        .out0_valid  (out0_valid),
        .out0_ready  (out0_ready),
        .end_valid   (end_valid),
        .end_ready   (end_ready),
        .o_dbg_state (dbg_state)
    );

    // Clock / cycle counter / watchdog
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Scoreboard: every accepted result must match the oldest expected value.
    always @(negedge clk) begin
        if (rst && out0_valid && out0_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out0", 32'(out0), 32'hFFFF_FFFF);
            end else begin
                check("out0_value", 32'(out0), 32'(exp_q.pop_front()));
                fire_cyc.push_back(cyc);
            end
        end
        if (rst && end_valid && end_ready) n_end++;
    end

    task automatic expect_result(input logic [2*W-1:0] v);
        exp_q.push_back(v);
        n_pushed++;
    endtask

    task automatic wait_handshake(input string name);
        bit hs = 0;
        for (int i = 0; i < 40 && !hs; i++) begin
            @(negedge clk);
            if (r_ready && start_ready) hs = 1;
        end
        check(name, 32'(hs), 32'd1);
    endtask

    // Returns cycles from the handshake edge until out0_valid is seen.
    task automatic wait_out_valid(output int lat);
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (out0_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_one(input logic [W-1:0] rv, input logic [2*W-1:0] ev);
        int lat;
        @(posedge clk); #1;
        r = rv; r_valid = 1'b1; start_valid = 1'b1;
        wait_handshake("vec_handshake");
        expect_result(ev);
        @(posedge clk); #1;
        r_valid = 1'b0; start_valid = 1'b0;
        wait_out_valid(lat);
        check("vec_latency", 32'(lat), 32'd9);
        check("vec_end_valid", 32'(end_valid), 32'd1);
        @(negedge clk);
        check("vec_out0_valid_drop", 32'(out0_valid), 32'd0);
        check("vec_end_valid_drop", 32'(end_valid), 32'd0);
    endtask

    task automatic drain(input string name);
        bit ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && dbg_state == S_IDLE) ok = 1;
        end
        check(name, 32'(ok), 32'd1);
    endtask

    initial begin
        int lat;
        int ends_before;
        vecs[0] = '{8'd13,  16'd169};
        vecs[1] = '{8'd0,   16'd0};
        vecs[2] = '{8'd255, 16'd65025};
        vecs[3] = '{8'd1,   16'd1};
        vecs[4] = '{8'd128, 16'd16384};
        vecs[5] = '{8'd170, 16'd28900};
        ops[0] = 8'd3; ops[1] = 8'd4; ops[2] = 8'd5;

        // Reset: readys gated even with both input valids high.
        r = 8'd9; r_valid = 1'b1; start_valid = 1'b1;
        out0_ready = 1'b1; end_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_r_ready", 32'(r_ready), 32'd0);
        check("rst_start_ready", 32'(start_ready), 32'd0);
        check("rst_out0", 32'(out0), 32'd0);
        check("rst_out0_valid", 32'(out0_valid), 32'd0);
        check("rst_end_valid", 32'(end_valid), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        @(posedge clk); #1;
        r_valid = 1'b0; start_valid = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 6; i++) run_one(vecs[i].r, vecs[i].exp);

        // Join: operand alone never handshakes.
        @(posedge clk); #1;
        r = 8'd9; r_valid = 1'b1; start_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("join_r_ready_low", 32'(r_ready), 32'd0);
            check("join_start_ready_low", 32'(start_ready), 32'd0);
        end
        @(posedge clk); #1;
        start_valid = 1'b1;
        @(negedge clk);
        check("join_r_ready_pulse", 32'(r_ready), 32'd1);
        check("join_start_ready_pulse", 32'(start_ready), 32'd1);
        expect_result(16'd81);
        @(negedge clk);
        check("join_r_ready_after", 32'(r_ready), 32'd0);
        @(posedge clk); #1;
        r_valid = 1'b0; start_valid = 1'b0;
        drain("join_drain");

        // Backpressure on out0 only.
        @(posedge clk); #1;
        out0_ready = 1'b0;
        r = 8'd200; r_valid = 1'b1; start_valid = 1'b1;
        wait_handshake("bp_handshake");
        expect_result(16'd40000);
        @(posedge clk); #1;
        r_valid = 1'b0; start_valid = 1'b0;
        wait_out_valid(lat);
        check("bp_latency", 32'(lat), 32'd9);
        check("bp_end_valid", 32'(end_valid), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("bp_end_dropped", 32'(end_valid), 32'd0);
            check("bp_out0_valid_held", 32'(out0_valid), 32'd1);
            check("bp_out0_stable", 32'(out0), 32'd40000);
        end
        @(posedge clk); #1;
        out0_ready = 1'b1;
        @(negedge clk);
        check("bp_out0_valid_at_ready", 32'(out0_valid), 32'd1);
        @(negedge clk);
        check("bp_idle_after", 32'(dbg_state), 32'(S_IDLE));
        check("bp_out0_valid_after", 32'(out0_valid), 32'd0);

        // Back-to-back operands with continuous valids.
        fire_cyc.delete();
        for (int k = 0; k < 3; k++) expect_result(16'(ops[k]) * 16'(ops[k]));
        @(posedge clk); #1;
        r = ops[0]; r_valid = 1'b1; start_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_handshake("b2b_handshake");
            @(posedge clk); #1;
            if (k < 2) r = ops[k+1];
            else begin
                r_valid = 1'b0; start_valid = 1'b0;
            end
        end
        for (int i = 0; i < 40 && fire_cyc.size() < 3; i++) @(negedge clk);
        check("b2b_count", 32'(fire_cyc.size()), 32'd3);
        if (fire_cyc.size() == 3) begin
            check("b2b_spacing_1", 32'(fire_cyc[1] - fire_cyc[0]), 32'd10);
            check("b2b_spacing_2", 32'(fire_cyc[2] - fire_cyc[1]), 32'd10);
        end
        drain("b2b_drain");

        // Reset in the middle of COMPUTE discards the operation.
        ends_before = n_end;
        @(posedge clk); #1;
        r = 8'd100; r_valid = 1'b1; start_valid = 1'b1;
        wait_handshake("rstmid_handshake");
        @(posedge clk); #1;
        r_valid = 1'b0; start_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("rstmid_out0", 32'(out0), 32'd0);
        check("rstmid_out0_valid", 32'(out0_valid), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'(S_IDLE));
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (12) @(negedge clk);
        check("rstmid_no_end", 32'(n_end), 32'(ends_before));
        check("rstmid_no_out0_valid", 32'(out0_valid), 32'd0);
        run_one(8'd7, 16'd49);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_end_count", 32'(n_end), 32'(n_pushed));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
